// File: rtl/mod_counter_pkg.sv
// Shared definitions for the counters-and-timers set: default width and the
// state encoding of the loadable modulo down-timer.
package mod_counter_pkg;

   // Default counter/modulus width shared with the up-counter.
   localparam int DEFAULT_WIDTH = 4;

   // IDLE  : no modulus loaded yet
   // RUN   : counting down
   // PAUSE : modulus loaded, count frozen until Start returns
   // DONE  : one-shot finished, waits for a new Load
   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } mod_timer_state_t;

endpackage

// File: rtl/mod_down_timer.sv
// Loadable modulo down-counter/timer. A modulus M is loaded, the count runs
// M-1 down to 0 and then either reloads (periodic) or stops (one-shot).
// Terminal_Count_Out is a registered one-cycle tick in the cycle after the
// count leaves 0, so in periodic mode ticks are exactly M cycles apart.
// A modulus of 0 stands for 2**WIDTH.
module mod_down_timer
   import mod_counter_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             Clk_In,
   input  logic             Reset_In,
   input  logic             Start_Stopb_In,
   input  logic             Load_In,
   input  logic [WIDTH-1:0] MOD_Value_In,
   input  logic             Auto_Reload_In,
   output logic [WIDTH-1:0] Count_Out,
   output logic             Terminal_Count_Out,
   output logic             Busy_Out,
   output mod_timer_state_t Dbg_State_Out
);

   mod_timer_state_t state_q, state_d;
   logic [WIDTH-1:0] count_q, count_d;
   logic [WIDTH-1:0] mod_q,   mod_d;
   logic             tc_q,    tc_d;

   // Registered state, count, captured modulus and tick; reset wins over all.
   always_ff @(posedge Clk_In) begin
      if (Reset_In) begin
         state_q <= ST_IDLE;
         count_q <= '0;
         mod_q   <= '0;
         tc_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         count_q <= count_d;
         mod_q   <= mod_d;
         tc_q    <= tc_d;
      end
   end

   // Next-state logic: Load overrides the normal per-state count update.
   always_comb begin
      state_d = state_q;
      count_d = count_q;
      mod_d   = mod_q;
      tc_d    = 1'b0;

      if (Load_In) begin
         // Subtraction wraps, so a modulus of 0 starts from all ones.
         mod_d   = MOD_Value_In;
         count_d = MOD_Value_In - WIDTH'(1);
         state_d = Start_Stopb_In ? ST_RUN : ST_PAUSE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               count_d = '0;
            end
            ST_RUN: begin
               if (!Start_Stopb_In) begin
                  state_d = ST_PAUSE;
               end else if (count_q != '0) begin
                  count_d = count_q - WIDTH'(1);
               end else begin
                  // Count leaving 0: tick, then reload or finish.
                  tc_d = 1'b1;
                  if (Auto_Reload_In) begin
                     count_d = mod_q - WIDTH'(1);
                  end else begin
                     state_d = ST_DONE;
                  end
               end
            end
            ST_PAUSE: begin
               // Resume only changes state; the first decrement is one edge later.
               if (Start_Stopb_In) begin
                  state_d = ST_RUN;
               end
            end
            ST_DONE: begin
               count_d = '0;
            end
            default: begin
               state_d = ST_IDLE;
               count_d = '0;
            end
         endcase
      end
   end

   // Outputs come straight from registers.
   always_comb begin
      Count_Out          = count_q;
      Terminal_Count_Out = tc_q;
      Busy_Out           = (state_q == ST_RUN);
      Dbg_State_Out      = state_q;
   end

endmodule

// File: tb/tb_mod_down_timer.sv
// Bench for mod_down_timer: directed scenarios with literal expectations,
// then randomized stimulus, all checked every cycle against a behavioural model.
module tb_mod_down_timer;
   import mod_counter_pkg::*;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         load = 1'b0;
   logic [W-1:0] mod_val = '0;
   logic         auto_rl = 1'b0;
   logic [W-1:0] count;
   logic         tc;
   logic         busy;
   mod_timer_state_t dbg_state;

   int checks = 0;
   int failures = 0;

   mod_down_timer #(.WIDTH(W)) dut (
      .Clk_In             (clk),
      .Reset_In           (rst),
      .Start_Stopb_In     (start),
      .Load_In            (load),
      .MOD_Value_In       (mod_val),
      .Auto_Reload_In     (auto_rl),
      .Count_Out          (count),
      .Terminal_Count_Out (tc),
      .Busy_Out           (busy),
      .Dbg_State_Out      (dbg_state)
   );

   // Clock
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   // Modes, a remaining-count integer and the period M = modulus (0 means 2**W).
   mod_timer_state_t m_state = ST_IDLE;
   int  m_cnt = 0;
   int  m_period = 0;
   bit  m_tc = 0;
   bit  m_valid = 0;

   function automatic int period_of(input logic [W-1:0] v);
      return (v == 0) ? (1 << W) : int'(v);
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_state = ST_IDLE; m_cnt = 0; m_period = 0; m_tc = 0; m_valid = 1;
      end else if (load) begin
         m_period = period_of(mod_val);
         m_cnt    = m_period - 1;
         m_state  = start ? ST_RUN : ST_PAUSE;
         m_tc     = 0;
      end else begin
         m_tc = 0;
         if (m_state == ST_RUN) begin
            if (!start) m_state = ST_PAUSE;
            else if (m_cnt > 0) m_cnt = m_cnt - 1;
            else begin
               m_tc = 1;
               if (auto_rl) m_cnt = m_period - 1;
               else m_state = ST_DONE;
            end
         end else if (m_state == ST_PAUSE && start) begin
            m_state = ST_RUN;
         end
      end
   end

   // Compare process: every cycle after the first reset edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("model_count", 32'(count), 32'(m_cnt));
         chk("model_tc",    32'(tc),    32'(m_tc));
         chk("model_busy",  32'(busy),  32'(m_state == ST_RUN));
         chk("model_state", 32'(dbg_state), 32'(m_state));
      end
   end

   // ---------------- driver ----------------
   task automatic step();
      @(negedge clk);
   endtask

   task automatic do_load(input logic [W-1:0] v, input logic a, input logic s);
      mod_val = v; auto_rl = a; start = s; load = 1'b1;
      step();
      load = 1'b0;
   endtask

   initial begin
      // 1. reset, then Start without Load stays idle
      rst = 1'b1; step(); rst = 1'b0;
      chk("reset_count", 32'(count), 0);
      chk("reset_busy",  32'(busy),  0);
      start = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         chk("idle_count", 32'(count), 0);
         chk("idle_tc",    32'(tc),    0);
         chk("idle_busy",  32'(busy),  0);
      end

      // 2. MOD=5 periodic
      do_load(4'd5, 1'b1, 1'b1);
      for (int i = 0; i < 16; i++) begin
         if (i > 0) step();
         chk("mod5_count", 32'(count), 32'(4 - (i % 5)));
         chk("mod5_tc",    32'(tc),    32'(i > 0 && i % 5 == 0));
      end

      // 3. MOD=3 one-shot
      do_load(4'd3, 1'b0, 1'b1);
      for (int i = 0; i < 14; i++) begin
         if (i > 0) step();
         chk("oneshot_count", 32'(count), (i < 3) ? 32'(2 - i) : 0);
         chk("oneshot_tc",    32'(tc),    32'(i == 3));
         chk("oneshot_busy",  32'(busy),  32'(i < 3));
      end

      // 4. MOD=10, pause at 6 for 4 cycles, resume
      do_load(4'd10, 1'b1, 1'b1);
      step(); step(); step();
      chk("pause_pre", 32'(count), 6);
      start = 1'b0;
      for (int i = 0; i < 4; i++) begin
         step();
         chk("pause_count", 32'(count), 6);
         chk("pause_busy",  32'(busy),  0);
      end
      start = 1'b1;
      step(); chk("resume_hold", 32'(count), 6); chk("resume_busy", 32'(busy), 1);
      step(); chk("resume_dec1", 32'(count), 5);
      step(); chk("resume_dec2", 32'(count), 4);

      // 5. edge moduli
      do_load(4'd0, 1'b1, 1'b1);
      for (int i = 0; i < 34; i++) begin
         if (i > 0) step();
         chk("mod0_count", 32'(count), 32'(15 - (i % 16)));
         chk("mod0_tc",    32'(tc),    32'(i > 0 && i % 16 == 0));
      end
      do_load(4'd1, 1'b1, 1'b1);
      for (int i = 0; i < 6; i++) begin
         if (i > 0) step();
         chk("mod1_count", 32'(count), 0);
         chk("mod1_tc",    32'(tc),    32'(i > 0));
      end

      // 6. mid-run load and reset priority
      do_load(4'd10, 1'b1, 1'b1);
      for (int i = 0; i < 7; i++) step();
      chk("midload_pre", 32'(count), 2);
      do_load(4'd7, 1'b1, 1'b1);
      chk("midload_count", 32'(count), 6);
      chk("midload_tc",    32'(tc),    0);
      rst = 1'b1; load = 1'b1; mod_val = 4'd9;
      step();
      rst = 1'b0; load = 1'b0;
      chk("rstload_count", 32'(count), 0);
      chk("rstload_tc",    32'(tc),    0);
      chk("rstload_state", 32'(dbg_state), 32'(ST_IDLE));

      // Randomized phase, checked by the model every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst     = ($urandom_range(0, 299) == 0);
         load    = ($urandom_range(0, 24) == 0);
         case ($urandom_range(0, 3))
            0: mod_val = '0;
            1: mod_val = 4'd1;
            default: mod_val = W'($urandom_range(0, 15));
         endcase
         start   = ($urandom_range(0, 9) != 0);
         auto_rl = ($urandom_range(0, 3) != 0);
         step();
      end
      rst = 1'b0; load = 1'b0;
      step();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
